// File: rtl/key_pkg.sv
// Shared types and constants for the push-button conditioner.
// Holds the channel FSM encoding, default timings and key indices.
package key_pkg;

    typedef enum logic [1:0] {
        DISARMED,
        IDLE,
        HELD,
        REPEAT
    } key_state_t;

    // Defaults for a 50 MHz clock.
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_RATE     = 5_000_000;

    // Key roles on the DE1-SoC board.
    localparam int KEY_MOVE_0 = 0;
    localparam int KEY_MOVE_1 = 1;
    localparam int KEY_START  = 3;

    // Bits needed to hold 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce counter and press/repeat FSM.
// Ports: clk, rst (async, active-low), key_n (raw, 0 = pressed),
//        key_level (debounced held), key_press / key_release (1-cycle strobes).
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_RATE));

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [1:0]    sync_q;
    logic          pressed;
    logic          db_q;
    logic [DW-1:0] db_cnt_q;
    logic          accept;
    logic          rise;
    logic          fall;

    key_state_t    state_q, state_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Synchroniser resets to the released level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n};
        end
    end

    assign pressed = ~sync_q[1];

    // The debounced level starts as "pressed" so that DISARMED only
    // leaves once a release has been seen stable for the full window.
    // A key held through reset therefore never looks like a new press.
    assign accept = (pressed != db_q) && (db_cnt_q == DB_LAST);
    assign rise   = accept & pressed;
    assign fall   = accept & ~pressed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q     <= 1'b1;
            db_cnt_q <= '0;
        end else if (pressed == db_q) begin
            db_cnt_q <= '0;
        end else if (accept) begin
            db_q     <= pressed;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DISARMED;
            rpt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpt_q     <= rpt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rpt_d     = rpt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            DISARMED: begin
                level_d = 1'b0;
                if (fall) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    rpt_d   = '0;
                end
            end
            HELD: begin
                // Release wins over a repeat falling due on the same edge.
                if (fall) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    rpt_d     = '0;
                end else if (REPEAT_EN) begin
                    if (rpt_q == DELAY_LAST) begin
                        state_d = REPEAT;
                        press_d = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    rpt_d     = '0;
                end else if (rpt_q == RATE_LAST) begin
                    press_d = 1'b1;
                    rpt_d   = '0;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end
            default: begin
                state_d = DISARMED;
                level_d = 1'b0;
                rpt_d   = '0;
            end
        endcase
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low push-buttons into clean levels and strobes.
// Ports: clk, rst (async, active-low), key_n[NKEYS] raw buttons,
//        key_level / key_press / key_release per key, all registered.
module key_conditioner
    import key_pkg::*;
#(
    parameter int               NKEYS           = 4,
    parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int               REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int               REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [NKEYS-1:0] REPEAT_MASK     = NKEYS'(4'b0011)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key_n,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release
);

    for (genvar i = 0; i < NKEYS; i++) begin : g_chan
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .key_n       (key_n[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with short timings.
// Expected strobes are queued as stimulus is driven and matched on output.
module tb_key_conditioner;

    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int RATE = 5;
    localparam int LAT = 2 + DEB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_n = 4'b0111;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    typedef struct {
        int         at;
        logic [3:0] press;
        logic [3:0] rel;
    } ev_t;

    ev_t exp_q[$];
    ev_t e;

    typedef struct {
        int key;
        int hold;
        int press_off;
        int rel_off;
    } vec_t;

    vec_t vecs[4];

    key_conditioner #(
        .NKEYS           (4),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (DLY),
        .REPEAT_RATE     (RATE),
        .REPEAT_MASK     (4'b0011)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "timeout");
    end

    // Scoreboard: every strobe cycle must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                total++;
                $display("FAIL missed_strobe: got none, required at %0d press=%b rel=%b",
                         exp_q[0].at, exp_q[0].press, exp_q[0].rel);
                void'(exp_q.pop_front());
            end
            if ((key_press | key_release) != 4'b0) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_strobe: got press=%b rel=%b at %0d, required none",
                             key_press, key_release, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at == cyc && e.press == key_press && e.rel == key_release)
                        passed++;
                    else
                        $display("FAIL strobe: got press=%b rel=%b at %0d, required press=%b rel=%b at %0d",
                                 key_press, key_release, cyc, e.press, e.rel, e.at);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic check_empty(input string name);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL %s: got %0d pending strobes, required 0", name, exp_q.size());
        exp_q.delete();
    endtask

    task automatic push(input int at, input logic [3:0] p, input logic [3:0] r);
        ev_t x;
        x.at = at;
        x.press = p;
        x.rel = r;
        exp_q.push_back(x);
    endtask

    // Return just after the posedge that brings cyc to t.
    task automatic at_pos(input int t);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < t);
    endtask

    // Return on the negedge following posedge t.
    task automatic at_neg(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    int n;
    int a;

    initial begin
        vecs[0] = '{key: 2, hold: 10, press_off: LAT, rel_off: 10 + LAT};
        vecs[1] = '{key: 3, hold: 10, press_off: LAT, rel_off: 10 + LAT};
        vecs[2] = '{key: 0, hold: 8,  press_off: LAT, rel_off: 8 + LAT};
        vecs[3] = '{key: 1, hold: 12, press_off: LAT, rel_off: 12 + LAT};

        // Reset with key 3 held through it.
        #3;
        chk("reset_level", {28'd0, key_level}, 32'd0);
        chk("reset_press", {28'd0, key_press}, 32'd0);
        chk("reset_release", {28'd0, key_release}, 32'd0);
        at_pos(3);
        rst = 1'b1;
        n = cyc;
        at_neg(n + 30);
        chk("held_thru_reset_level", {31'd0, key_level[3]}, 32'd0);
        check_empty("held_thru_reset_silent");
        at_pos(n + 30);
        key_n[3] = 1'b1;
        at_pos(n + 45);
        check_empty("disarm_release_silent");
        key_n[3] = 1'b0;
        n = cyc;
        push(n + LAT, 4'b1000, 4'b0000);
        at_neg(n + LAT);
        chk("rearmed_level3", {31'd0, key_level[3]}, 32'd1);
        at_pos(n + 10);
        key_n[3] = 1'b1;
        push(n + 10 + LAT, 4'b0000, 4'b1000);
        at_neg(n + 20);
        check_empty("rearmed_done");

        // Clean press/release table.
        for (int i = 0; i < 4; i++) begin
            at_pos(cyc + 2);
            n = cyc;
            key_n[vecs[i].key] = 1'b0;
            push(n + vecs[i].press_off, 4'(1 << vecs[i].key), 4'b0000);
            push(n + vecs[i].rel_off, 4'b0000, 4'(1 << vecs[i].key));
            at_neg(n + vecs[i].press_off - 1);
            chk($sformatf("lvl_before_k%0d", vecs[i].key),
                {31'd0, key_level[vecs[i].key]}, 32'd0);
            at_neg(n + vecs[i].press_off);
            chk($sformatf("lvl_rise_k%0d", vecs[i].key),
                {31'd0, key_level[vecs[i].key]}, 32'd1);
            at_pos(n + vecs[i].hold);
            key_n[vecs[i].key] = 1'b1;
            at_neg(n + vecs[i].rel_off);
            chk($sformatf("lvl_fall_k%0d", vecs[i].key),
                {31'd0, key_level[vecs[i].key]}, 32'd0);
            at_neg(n + vecs[i].rel_off + 4);
            check_empty($sformatf("vec_k%0d_done", vecs[i].key));
        end

        // Bounce on key 0: last edge of the raw input starts the window.
        at_pos(cyc + 2);
        n = cyc;
        key_n[0] = 1'b0;
        at_pos(n + 3);
        key_n[0] = 1'b1;
        at_pos(n + 4);
        key_n[0] = 1'b0;
        push(n + 4 + LAT, 4'b0001, 4'b0000);
        at_neg(n + 4 + LAT - 1);
        chk("bounce_no_early_level", {31'd0, key_level[0]}, 32'd0);
        at_pos(n + 14);
        key_n[0] = 1'b1;
        push(n + 14 + LAT, 4'b0000, 4'b0001);
        at_neg(n + 24);
        check_empty("bounce_done");

        // Auto-repeat on key 0; release lands on a due repeat and drops it.
        at_pos(cyc + 2);
        n = cyc;
        key_n[0] = 1'b0;
        a = n + LAT;
        push(a, 4'b0001, 4'b0000);
        push(a + DLY, 4'b0001, 4'b0000);
        push(a + DLY + RATE, 4'b0001, 4'b0000);
        push(a + DLY + 2 * RATE, 4'b0001, 4'b0000);
        push(a + DLY + 3 * RATE, 4'b0001, 4'b0000);
        push(a + 40, 4'b0000, 4'b0001);
        at_pos(a + 40 - LAT);
        key_n[0] = 1'b1;
        at_neg(a + 50);
        check_empty("repeat_done");

        // Keys 0 and 3 pressed together.
        at_pos(cyc + 2);
        n = cyc;
        key_n[0] = 1'b0;
        key_n[3] = 1'b0;
        push(n + LAT, 4'b1001, 4'b0000);
        at_neg(n + LAT);
        chk("simul_level", {28'd0, key_level}, 32'h9);
        at_pos(n + 8);
        key_n[0] = 1'b1;
        key_n[3] = 1'b1;
        push(n + 8 + LAT, 4'b0000, 4'b1001);
        at_neg(n + 18);
        check_empty("simul_done");

        // Reset while key 1 is repeating.
        at_pos(cyc + 2);
        n = cyc;
        key_n[1] = 1'b0;
        a = n + LAT;
        push(a, 4'b0010, 4'b0000);
        push(a + DLY, 4'b0010, 4'b0000);
        at_neg(a + DLY + 2);
        check_empty("pre_reset_repeat");
        chk("pre_reset_level1", {31'd0, key_level[1]}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_level", {28'd0, key_level}, 32'd0);
        chk("async_reset_press", {28'd0, key_press}, 32'd0);
        chk("async_reset_release", {28'd0, key_release}, 32'd0);
        at_pos(cyc + 3);
        rst = 1'b1;
        n = cyc;
        at_neg(n + 30);
        chk("post_reset_level1", {31'd0, key_level[1]}, 32'd0);
        check_empty("post_reset_silent");
        at_pos(n + 30);
        key_n[1] = 1'b1;
        at_pos(n + 45);
        check_empty("post_reset_release_silent");
        key_n[1] = 1'b0;
        n = cyc;
        push(n + LAT, 4'b0010, 4'b0000);
        at_pos(n + 10);
        key_n[1] = 1'b1;
        push(n + 10 + LAT, 4'b0000, 4'b0010);
        at_neg(n + 20);
        check_empty("post_reset_rearm");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Conditions the raw active-low DE1-SoC push-buttons before they reach the game controller and the top-level START/PLAYING/DONE state machine. Each key is synchronised, debounced and turned into a clean level plus single-cycle press/release strobes; the movement keys additionally auto-repeat while held. The block sits directly upstream of the game controller's KEY input and of the start/restart logic, replacing the direct use of `~KEY[n]`.

## Interface
Parameters:
- `NKEYS`, 4, number of key channels
- `DEBOUNCE_CYCLES`, 1_000_000, cycles a new level must be stable before acceptance (20 ms at 50 MHz)
- `REPEAT_DELAY`, 25_000_000, cycles from accepted press to first repeat strobe (500 ms)
- `REPEAT_RATE`, 5_000_000, cycles between subsequent repeat strobes (100 ms)
- `REPEAT_MASK`, 4'b0011, bit n = 1 enables auto-repeat on key n

Ports:
- `clk`  in  1  system clock (CLOCK_50); only clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `key_n`  in  NKEYS  raw buttons, 0 = pressed, asynchronous to clk
- `key_level`  out  NKEYS  debounced state, 1 = held
- `key_press`  out  NKEYS  1-cycle strobe on accepted press and on each repeat
- `key_release`  out  NKEYS  1-cycle strobe on accepted release

## Operation
- Per key: 2-flop synchroniser, then debounce counter, then channel FSM; channels fully independent.
- Debounce: counter clears whenever synchronised input equals `key_level`; otherwise increments; when it reaches `DEBOUNCE_CYCLES-1` the new level is accepted and counter clears. Any bounce back clears the counter (no partial credit).
- Channel FSM states: `DISARMED`, `IDLE`, `HELD`, `REPEAT`.
  - `DISARMED` (reset state): `key_level`=0, no strobes. Moves to `IDLE` once the debounced input is released. A key held through reset produces no press until it is released and pressed again.
  - `IDLE` → `HELD` on accepted press: `key_level`→1, `key_press` strobe, repeat counter cleared.
  - `HELD`: if mask bit set, counter counts to `REPEAT_DELAY-1`, then `key_press` strobe and → `REPEAT`. Mask bit clear: stays until release.
  - `REPEAT`: `key_press` strobe every `REPEAT_RATE` cycles while held.
  - `HELD`/`REPEAT` → `IDLE` on accepted release: `key_level`→0, `key_release` strobe, repeat counter cleared; a repeat due in the same cycle is dropped.
- Simultaneous presses on multiple keys yield simultaneous strobes; no priority.
- Counter widths: `$clog2(max(param)+1)`; counters saturate-free, always cleared before overflow.

## Timing
- Reset: synchroniser flops = 1 (released), all counters 0, FSM `DISARMED`, all outputs 0.
- All outputs registered. Press latency from `key_n` falling (stable thereafter): 2 sync cycles + `DEBOUNCE_CYCLES` cycles → `key_level` rises and `key_press` high for exactly 1 cycle, same edge.
- First repeat `REPEAT_DELAY` cycles after the initial press strobe; then every `REPEAT_RATE` cycles.
- Release latency symmetric: 2 + `DEBOUNCE_CYCLES` cycles.
- Reset asserted mid-operation: outputs clear asynchronously; in-flight strobes lost; channel re-enters `DISARMED`.

## Structure
- Shared package `key_pkg`: FSM state enum (`DISARMED`, `IDLE`, `HELD`, `REPEAT`), default timing constants, key index constants (`KEY_START`=3, movement keys 0–1).
- One sub-module `key_channel` (synchroniser + debounce + FSM for a single key, repeat-enable as a 1-bit parameter); top instantiates `NKEYS` copies via generate.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_RATE`=5.
- Clean press on key 2 held 10 cycles → `key_level[2]` rises 6 cycles after edge, single `key_press[2]` pulse, `key_release[2]` 6 cycles after release; no repeats (mask bit 0).
- Bounce on key 0: 3-cycle low, 1-cycle high, 3-cycle low, then stable low → no strobe until 4 consecutive stable cycles; exactly one `key_press[0]`.
- Hold key 0 for 40 cycles after acceptance → `key_press[0]` at t=0, 20, 25, 30, 35; on release no further strobes, one `key_release[0]`.
- Key 3 held low across reset deassertion for 30 cycles → no `key_press[3]`; release then press → one strobe after debounce.
- Keys 0 and 3 pressed on the same edge → `key_press[0]` and `key_press[3]` on the same cycle.
- Reset asserted while key 1 in `REPEAT` → all outputs 0 immediately; after reset, held key 1 stays silent until released.
